score_to_digits: RTL and testbench

//  Converts a binary score/counter value into NUM_DIGITS packed BCD digits for the
//  per-digit bitmap renderers. It sits between game logic (the value source) and the

---
 rtl/score_to_digits.sv | 133 +++++++++++++
 tb/tb_score_to_digits.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_to_digits.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per clock)
// with saturation, overflow flag and leading-zero blanking.
module score_to_digits #(
   parameter int IN_WIDTH   = 14,
   parameter int NUM_DIGITS = 4,
   parameter int MAX_VALUE  = 9999
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [IN_WIDTH-1:0]     value,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    digits_valid,
   output logic                    overflow,
   output logic [NUM_DIGITS-1:0]   leading_blank
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(IN_WIDTH + 1);
   localparam logic [IN_WIDTH-1:0] MAX_V = IN_WIDTH'(MAX_VALUE);
   localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [BW-1:0]       bcd_adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_s_q, ovf_s_d;
   logic                done_q, done_d;
   logic [BW-1:0]       digits_q, digits_d;
   logic                valid_q, valid_d;
   logic                overflow_q, overflow_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic                zero_run;

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_s_d    = ovf_s_q;
      done_d     = 1'b0;
      digits_d   = digits_q;
      valid_d    = valid_q;
      overflow_d = overflow_q;
      blank_d    = blank_q;
      zero_run   = 1'b1;
      bcd_adj    = bcd_q;

      // add-3 correction applied before each shift
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d   = (value > MAX_V) ? MAX_V : value;
               ovf_s_d = (value > MAX_V);
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            digits_d   = bcd_q;
            overflow_d = ovf_s_q;
            valid_d    = 1'b1;
            done_d     = 1'b1;
            state_d    = S_IDLE;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
               zero_run   = zero_run & (bcd_q[4*i +: 4] == 4'd0);
               blank_d[i] = zero_run;
            end
            blank_d[0] = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_s_q    <= 1'b0;
         done_q     <= 1'b0;
         digits_q   <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         blank_q    <= '0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_s_q    <= ovf_s_d;
         done_q     <= done_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         blank_q    <= blank_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign digits        = digits_q;
   assign digits_valid  = valid_q;
   assign overflow      = overflow_q;
   assign leading_blank = blank_q;

endmodule

// File: tb/tb_score_to_digits.sv
// Bench for score_to_digits: directed cases with literal expectations
// plus randomized traffic against a cycle-level behavioural model.
module tb_score_to_digits;

   localparam int IN_WIDTH = 14;
   localparam int NUM_DIGITS = 4;
   localparam int MAX_VALUE = 9999;
   localparam int BUSY_LEN = IN_WIDTH + 1;

   logic                clk;
   logic                reset;
   logic                start;
   logic [IN_WIDTH-1:0] value;
   logic                busy;
   logic                done;
   logic [15:0]         digits;
   logic                digits_valid;
   logic                overflow;
   logic [3:0]          leading_blank;

   int n_checks = 0;
   int n_err = 0;
   bit chk_en = 0;

   score_to_digits #(
      .IN_WIDTH(IN_WIDTH),
      .NUM_DIGITS(NUM_DIGITS),
      .MAX_VALUE(MAX_VALUE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .value(value),
      .busy(busy),
      .done(done),
      .digits(digits),
      .digits_valid(digits_valid),
      .overflow(overflow),
      .leading_blank(leading_blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] blank_of(input int v);
      logic [3:0] r;
      int p;
      r = '0;
      p = 10;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         r[i] = (v < p);
         p = p * 10;
      end
      return r;
   endfunction

   // behavioural model: a countdown of remaining busy cycles
   int          m_rem = 0;
   int          m_val = 0;
   bit          m_pend_ovf = 0;
   bit          m_done = 0;
   bit          m_valid = 0;
   bit          m_ovf = 0;
   logic [15:0] m_digits = '0;
   logic [3:0]  m_lb = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_rem = 0;
         m_done = 0;
         m_valid = 0;
         m_ovf = 0;
         m_digits = '0;
         m_lb = '0;
      end else begin
         m_done = 0;
         if (m_rem == 0) begin
            if (start) begin
               m_val = (int'(value) > MAX_VALUE) ? MAX_VALUE : int'(value);
               m_pend_ovf = (int'(value) > MAX_VALUE);
               m_rem = BUSY_LEN;
            end
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_digits = to_bcd(m_val);
               m_lb = blank_of(m_val);
               m_ovf = m_pend_ovf;
               m_valid = 1;
               m_done = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if ({busy, done, digits, digits_valid, overflow, leading_blank} !==
             {(m_rem != 0), m_done, m_digits, m_valid, m_ovf, m_lb}) begin
            n_err++;
            $display("FAIL model_cmp t=%0t: busy/done/digits/valid/ovf/lb got %b/%b/%h/%b/%b/%b required %b/%b/%h/%b/%b/%b",
                     $time, busy, done, digits, digits_valid, overflow, leading_blank,
                     (m_rem != 0), m_done, m_digits, m_valid, m_ovf, m_lb);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // called at a negedge with the DUT idle; returns at the negedge where done is seen
   task automatic convert(input int v, input logic [15:0] ed, input logic [3:0] elb, input logic eovf);
      int n;
      int nb;
      start = 1'b1;
      value = IN_WIDTH'(v);
      @(negedge clk);
      start = 1'b0;
      value = IN_WIDTH'($urandom);
      n = 1;
      nb = 0;
      while (!done && n < 40) begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end
      check("latency", n, BUSY_LEN + 1);
      check("busy_cycles", nb, BUSY_LEN);
      check("done_seen", done, 1);
      check("busy_in_done", busy, 0);
      check("digits", digits, ed);
      check("leading_blank", leading_blank, elb);
      check("overflow", overflow, eovf);
      check("digits_valid", digits_valid, 1);
   endtask

   initial begin
      int dones;
      reset = 1'b1;
      start = 1'b0;
      value = '0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_digits", digits, 0);
      check("rst_valid", digits_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_lb", leading_blank, 0);
      reset = 1'b0;
      @(negedge clk);

      convert(0, 16'h0000, 4'b1110, 1'b0);
      @(negedge clk);
      convert(1234, 16'h1234, 4'b0000, 1'b0);
      @(negedge clk);
      check("done_width", done, 0);
      check("hold_digits", digits, 16'h1234);

      convert(9999, 16'h9999, 4'b0000, 1'b0);
      convert(7, 16'h0007, 4'b1110, 1'b0);
      @(negedge clk);

      convert(12000, 16'h9999, 4'b0000, 1'b1);
      @(negedge clk);
      convert(5, 16'h0005, 4'b1110, 1'b0);
      @(negedge clk);

      start = 1'b1;
      value = IN_WIDTH'(5678);
      @(negedge clk);
      dones = 0;
      for (int n = 1; n <= 30; n++) begin
         if (done) dones++;
         start = (n == 5);
         if (n == 5) value = IN_WIDTH'(42);
         @(negedge clk);
      end
      check("busy_start_dones", dones, 1);
      check("busy_start_digits", digits, 16'h5678);

      start = 1'b1;
      value = IN_WIDTH'(4321);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_digits", digits, 0);
      check("abort_valid", digits_valid, 0);
      dones = 0;
      repeat (20) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("abort_no_done", dones, 0);
      convert(321, 16'h0321, 4'b1000, 1'b0);
      @(negedge clk);

      for (int c = 0; c < 4000; c++) begin
         start = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 299) == 0);
         case ($urandom_range(0, 3))
            0: value = IN_WIDTH'($urandom_range(9990, 10010));
            1: value = IN_WIDTH'($urandom_range(0, 20));
            2: value = IN_WIDTH'($urandom_range(0, 9999));
            default: value = IN_WIDTH'($urandom);
         endcase
         @(negedge clk);
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
